// File: rtl/fetch_inst_queue_pkg.sv
// Shared constants and types for the fetch instruction queue.
// Optional statistics ports are enabled with the IQ_STAT_EN macro.
package fetch_inst_queue_pkg;

  localparam int InstWidth = 32;
  localparam int IQDepth   = 8;
  localparam int IQEntryW  = 64;

  // One queued instruction: PC in the upper word, instruction in the lower word
  typedef struct packed {
    logic [InstWidth-1:0] pc;
    logic [InstWidth-1:0] inst;
  } iq_entry_t;

  // Words delivered by an 8-byte block: the upper word only when the PC points at it
  function automatic logic [1:0] fetch_words(input logic pc_bit2);
    return pc_bit2 ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/fetch_inst_queue_iq_regfile.sv
// Queue entry storage: DEPTH entries, two write ports, two async read ports.
// Write port 1 wins on an index collision. Storage is not reset.
module iq_regfile
  import fetch_inst_queue_pkg::*;
#(
  parameter int DEPTH = IQDepth,
  parameter int AW    = 3
) (
  input  logic            clk,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  iq_entry_t       wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  iq_entry_t       wd1,
  input  logic [AW-1:0]   ra0,
  output iq_entry_t       rd0,
  input  logic [AW-1:0]   ra1,
  output iq_entry_t       rd1
);

  iq_entry_t mem_q [DEPTH];

  // Entry writes; port 1 is applied last so it takes priority
  always_ff @(posedge clk) begin
    if (we0) mem_q[wa0] <= wd0;
    if (we1) mem_q[wa1] <= wd1;
  end

  assign rd0 = mem_q[ra0];
  assign rd1 = mem_q[ra1];

endmodule

// File: rtl/fetch_inst_queue.sv
// Instruction buffer between fetch and decode: accepts 1-2 words per cycle,
// issues 0-2 per cycle in program order. Flush discards all entries.
// Define IQ_STAT_EN to add the iq_count / iq_stall_cnt statistics ports.
module fetch_inst_queue
  import fetch_inst_queue_pkg::*;
#(
  parameter int DEPTH = IQDepth,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 fetch_valid,
  input  logic [InstWidth-1:0] fetch_pc,
  input  logic [InstWidth-1:0] fetch_inst0,
  input  logic [InstWidth-1:0] fetch_inst1,
  output logic                 fetch_ready,
  output logic                 out_valid0,
  output logic [InstWidth-1:0] out_pc0,
  output logic [InstWidth-1:0] out_inst0,
  output logic                 out_valid1,
  output logic [InstWidth-1:0] out_pc1,
  output logic [InstWidth-1:0] out_inst1,
  input  logic [1:0]           dec_accept
`ifdef IQ_STAT_EN
  ,
  output logic [AW:0]          iq_count,
  output logic [31:0]          iq_stall_cnt
`endif
);

  logic [AW:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic        wr_en;
  logic [1:0]  n_wr, n_pop;
  iq_entry_t   wd0, wd1, rd0, rd1;
  logic [AW-1:0] wa0, wa1, ra0, ra1;

  // Ready from the pre-pop count so dec_accept never reaches fetch_ready
  always_comb begin
    fetch_ready = (count_q <= (AW+1)'(DEPTH - 2));
    wr_en       = fetch_valid && fetch_ready && !flush;
    n_wr        = wr_en ? fetch_words(fetch_pc[2]) : 2'd0;
    // Illegal over-accept is clamped to what is actually held
    n_pop       = ((AW+1)'(dec_accept) > count_q) ? count_q[1:0] : dec_accept;
  end

  // Pointer and occupancy update; flush overrides both push and pop
  always_comb begin
    head_d  = head_q + (AW+1)'(n_pop);
    tail_d  = tail_q + (AW+1)'(n_wr);
    count_d = count_q + (AW+1)'(n_wr) - (AW+1)'(n_pop);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and count state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write-port steering: a single-word block carries the upper word at tail
  always_comb begin
    wa0      = tail_q[AW-1:0];
    wa1      = tail_q[AW-1:0] + AW'(1);
    wd0.pc   = fetch_pc;
    wd0.inst = fetch_pc[2] ? fetch_inst1 : fetch_inst0;
    wd1.pc   = fetch_pc + 32'd4;
    wd1.inst = fetch_inst1;
    ra0      = head_q[AW-1:0];
    ra1      = head_q[AW-1:0] + AW'(1);
  end

  iq_regfile #(.DEPTH(DEPTH), .AW(AW)) u_rf (
    .clk (clk),
    .we0 (wr_en),
    .wa0 (wa0),
    .wd0 (wd0),
    .we1 (wr_en && !fetch_pc[2]),
    .wa1 (wa1),
    .wd1 (wd1),
    .ra0 (ra0),
    .rd0 (rd0),
    .ra1 (ra1),
    .rd1 (rd1)
  );

  assign out_valid0 = (count_q != '0);
  assign out_valid1 = (count_q >= (AW+1)'(2));
  assign out_pc0    = rd0.pc;
  assign out_inst0  = rd0.inst;
  assign out_pc1    = rd1.pc;
  assign out_inst1  = rd1.inst;

  // Decode must never take more than is held, nor the reserved value 3
  a_dec_accept: assert property (@(posedge clk) disable iff (rst || flush)
    (dec_accept != 2'b11) && ((AW+1)'(dec_accept) <= count_q));

`ifdef IQ_STAT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where fetch was blocked; flush does not clear it
  always_comb begin
    stall_d = stall_q;
    if (fetch_valid && !fetch_ready && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  // Stall counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign iq_count     = count_q;
  assign iq_stall_cnt = stall_q;
`endif

endmodule
